tick_counter: RTL and testbench

TICK_COUNTER -- requirements
Module: tick_counter

---
 rtl/tick_counter.sv | 123 ++++++++++++
 tb/tb_tick_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// Prescaled up/down tick counter with wrap and one-shot modes.
// The count advances once per DIV clk_i cycles, entirely in the clk_i domain.
module tick_counter #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MAX_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic [MAX_W-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             done_o
);

    if (TICK_HZ == 0 || TICK_HZ > CLK_HZ || MAX_W > WIDTH) begin : g_bad_params
        $error("tick_counter: invalid CLK_HZ/TICK_HZ/MAX_W/WIDTH combination");
    end

    localparam int unsigned DIV    = (TICK_HZ == 0) ? 1 : CLK_HZ / TICK_HZ;
    localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [MAX_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    // Next-state logic; tick_q marks the cycle in which the prescaler sits at DIV-1.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;

        if (clear_i) begin
            presc_d = '0;
            cnt_d   = dir_i ? max_i : '0;
            done_d  = 1'b0;
        end else begin
            if (en_i) begin
                // Prescaler parked at DIV-1 without a tick (enable dropped on the tick cycle)
                if (presc_q == DIV_M1 && !tick_q) begin
                    tick_d = 1'b1;
                end else begin
                    presc_d = (presc_q == DIV_M1) ? '0 : presc_q + PW'(1);
                    tick_d  = (presc_d == DIV_M1);
                end

                if (tick_q && !done_q) begin
                    if (!dir_i) begin
                        if (cnt_q >= max_i) begin
                            if (mode_i) begin
                                done_d = 1'b1;
                            end else begin
                                cnt_d  = '0;
                                wrap_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + MAX_W'(1);
                            if (mode_i && cnt_d == max_i) begin
                                done_d = 1'b1;
                            end
                        end
                    end else begin
                        if (cnt_q > max_i) begin
                            cnt_d = max_i;
                        end else if (cnt_q == '0) begin
                            if (mode_i) begin
                                done_d = 1'b1;
                            end else begin
                                cnt_d  = max_i;
                                wrap_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - MAX_W'(1);
                            if (mode_i && cnt_d == '0) begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
            end

            // A zero terminal pins the count regardless of tick or enable
            if (max_i == '0) begin
                cnt_d  = '0;
                wrap_d = 1'b0;
                done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count_o = WIDTH'(cnt_q);
    assign tick_o  = tick_q;
    assign wrap_o  = wrap_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter at DIV=10 (CLK_HZ=10, TICK_HZ=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tick_counter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned MAX_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             en_i;
    logic             clear_i;
    logic             dir_i;
    logic             mode_i;
    logic [MAX_W-1:0] max_i;
    logic [WIDTH-1:0] count_o;
    logic             tick_o;
    logic             wrap_o;
    logic             done_o;

    int n_cmp = 0;
    int n_bad = 0;

    tick_counter #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .WIDTH  (WIDTH),
        .MAX_W  (MAX_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .clear_i(clear_i),
        .dir_i  (dir_i),
        .mode_i (mode_i),
        .max_i  (max_i),
        .count_o(count_o),
        .tick_o (tick_o),
        .wrap_o (wrap_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One clear edge with the given direction/mode/terminal, enable high
    task automatic do_clear(input logic dir, input logic mode, input logic [MAX_W-1:0] max);
        dir_i   = dir;
        mode_i  = mode;
        max_i   = max;
        en_i    = 1'b1;
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cnt [4];
        int          wraps;
        exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd0};

        rst_ni  = 1'b0;
        en_i    = 1'b0;
        clear_i = 1'b0;
        dir_i   = 1'b0;
        mode_i  = 1'b0;
        max_i   = 8'd3;
        step(2);
        check("rst_count", count_o, 0);
        check("rst_tick", 32'(tick_o), 0);
        check("rst_wrap", 32'(wrap_o), 0);
        check("rst_done", 32'(done_o), 0);

        // Up, wrap, max 3: ticks on cycles 9,19,...; count 1,2,3,0 with wrap at the 4th
        rst_ni = 1'b1;
        en_i   = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            check("up_wrap_tick", 32'(tick_o), (i % 10 == 9) ? 1 : 0);
            check("up_wrap_wrap", 32'(wrap_o), (i == 40) ? 1 : 0);
            if (i % 10 == 0 && i <= 40) begin
                check("up_wrap_count", count_o, exp_cnt[i/10 - 1]);
            end
        end
        en_i = 1'b0;

        // Down, one-shot, max 2: 2,1,0 with done at the 2nd tick, then hold
        do_clear(1'b1, 1'b1, 8'd2);
        check("os_clear_count", count_o, 2);
        wraps = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (wrap_o) wraps++;
            if (i == 10) begin
                check("os_count_t1", count_o, 1);
                check("os_done_t1", 32'(done_o), 0);
            end
            if (i == 20) begin
                check("os_count_t2", count_o, 0);
                check("os_done_t2", 32'(done_o), 1);
            end
        end
        check("os_count_hold", count_o, 0);
        check("os_done_hold", 32'(done_o), 1);
        check("os_no_wrap", 32'(wraps), 0);

        // Count 5, terminal lowered to 2 while counting up
        do_clear(1'b1, 1'b0, 8'd5);
        check("lower_start", count_o, 5);
        dir_i = 1'b0;
        max_i = 8'd2;
        step(9);
        check("lower_tick", 32'(tick_o), 1);
        check("lower_pre_count", count_o, 5);
        step(1);
        check("lower_up_count", count_o, 0);
        check("lower_up_wrap", 32'(wrap_o), 1);
        step(1);
        check("lower_wrap_pulse", 32'(wrap_o), 0);

        // Count 7, terminal lowered to 3 while counting down: reload without wrap
        do_clear(1'b1, 1'b0, 8'd7);
        max_i = 8'd3;
        step(10);
        check("lower_dn_count", count_o, 3);
        check("lower_dn_wrap", 32'(wrap_o), 0);

        // Terminal 0 forces count to 0 on the next clock; prescaler keeps running
        max_i = 8'd0;
        step(1);
        check("max0_count", count_o, 0);
        check("max0_wrap", 32'(wrap_o), 0);
        check("max0_done", 32'(done_o), 0);
        step(8);
        check("max0_tick", 32'(tick_o), 1);
        step(1);
        check("max0_count_tick", count_o, 0);
        check("max0_wrap_tick", 32'(wrap_o), 0);

        // Enable low for 7 cycles with prescaler at 4
        do_clear(1'b0, 1'b0, 8'd3);
        step(4);
        en_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("en_low_tick", 32'(tick_o), 0);
        end
        check("en_low_count", count_o, 0);
        en_i = 1'b1;
        step(4);
        check("en_resume_early", 32'(tick_o), 0);
        step(1);
        check("en_resume_tick", 32'(tick_o), 1);
        step(1);
        check("en_resume_count", count_o, 1);

        // Asynchronous reset between edges at count 2
        do_clear(1'b1, 1'b0, 8'd2);
        step(3);
        check("arst_pre_count", count_o, 2);
        rst_ni = 1'b0;
        #2;
        check("arst_count", count_o, 0);
        check("arst_tick", 32'(tick_o), 0);
        check("arst_wrap", 32'(wrap_o), 0);
        check("arst_done", 32'(done_o), 0);
        #1;
        rst_ni = 1'b1;
        step(8);
        check("arst_no_early_tick", 32'(tick_o), 0);
        step(1);
        check("arst_first_tick", 32'(tick_o), 1);
        step(1);
        check("arst_dn_reload", count_o, 2);
        check("arst_dn_wrap", 32'(wrap_o), 1);

        // Clear on the tick cycle with count at terminal
        dir_i = 1'b0;
        step(9);
        check("clr_tick", 32'(tick_o), 1);
        check("clr_pre_count", count_o, 2);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        check("clr_count", count_o, 0);
        check("clr_wrap", 32'(wrap_o), 0);
        check("clr_tick_off", 32'(tick_o), 0);
        step(8);
        check("clr_restart_early", 32'(tick_o), 0);
        step(1);
        check("clr_restart_tick", 32'(tick_o), 1);
        step(1);
        check("clr_restart_count", count_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
